mcpu_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port MCPU RAM among three requesters: instruction fetch (0), data load/store (1) and the external program loader (2). It replaces direct hierarchical writes into the RAM array, so programs load through a real port while the CPU runs or stalls. The arbiter sits between the MCPU control unit or loader and the RAM instance. It issues at most one RAM access per cycle and routes read data back to the requester that issued the read.

---
 rtl/mcpu_pkg.sv | 16 +
 rtl/mcpu_mem_arbiter_if.sv | 26 ++
 rtl/mcpu_rr_pick.sv | 28 ++
 rtl/mcpu_mem_arbiter.sv | 55 +++++
 tb/tb_mcpu_mem_arbiter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mcpu_pkg.sv
// Shared MCPU memory-system constants: bus widths, requester count and requester indices.
// Pure declarations plus the round-robin pointer advance helper.
package mcpu_pkg;
    localparam int WORD_SIZE  = 16;
    localparam int ADDR_WIDTH = 8;
    localparam int NREQ       = 3;
    localparam int PTR_W      = 2;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_LOAD  = 2;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction
endpackage

// File: rtl/mcpu_mem_arbiter_if.sv
// Requester-side and RAM-side signals of the MCPU memory arbiter, bundled for one port.
// slave = arbiter view, master = requesters plus RAM view.
interface mcpu_mem_arbiter_if;
    logic [mcpu_pkg::NREQ-1:0]                       req;
    logic [mcpu_pkg::NREQ-1:0]                       we;
    logic [mcpu_pkg::NREQ*mcpu_pkg::ADDR_WIDTH-1:0]  addr;
    logic [mcpu_pkg::NREQ*mcpu_pkg::WORD_SIZE-1:0]   wdata;
    logic [mcpu_pkg::NREQ-1:0]                       gnt;
    logic [mcpu_pkg::NREQ-1:0]                       rvalid;
    logic [mcpu_pkg::WORD_SIZE-1:0]                  rdata;
    logic                                            ram_en;
    logic                                            ram_we;
    logic [mcpu_pkg::ADDR_WIDTH-1:0]                 ram_addr;
    logic [mcpu_pkg::WORD_SIZE-1:0]                  ram_wdata;
    logic [mcpu_pkg::WORD_SIZE-1:0]                  ram_rdata;

    modport slave (
        input  req, we, addr, wdata, ram_rdata,
        output gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req, we, addr, wdata, ram_rdata,
        input  gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mcpu_rr_pick.sv
// Combinational round-robin one-hot picker: search starts at i_ptr and wraps modulo NREQ.
// Zero latency, no state; o_any flags that some requester won.
module mcpu_rr_pick
    import mcpu_pkg::*;
(
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [PTR_W-1:0] o_win,
    output logic             o_any
);
    int w_idx;

    always_comb begin
        o_gnt = '0;
        o_win = '0;
        o_any = 1'b0;
        w_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (!o_any && i_req[PTR_W'(w_idx)]) begin
                o_gnt[PTR_W'(w_idx)] = 1'b1;
                o_win                = PTR_W'(w_idx);
                o_any                = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mcpu_mem_arbiter.sv
// Round-robin arbiter sharing the single-port MCPU RAM among fetch, data and loader.
// Grant is same-cycle; rvalid follows a granted read by one cycle. Losers hold their request.
module mcpu_mem_arbiter
    import mcpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    mcpu_mem_arbiter_if.slave  bus
);
    logic [PTR_W-1:0]      r_ptr;
    logic [NREQ-1:0]       r_rd_tag;

    logic [NREQ-1:0]       w_req;
    logic [NREQ-1:0]       w_gnt;
    logic [PTR_W-1:0]      w_win;
    logic                  w_any;
    logic [ADDR_WIDTH-1:0] w_addr  [NREQ];
    logic [WORD_SIZE-1:0]  w_wdata [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_addr[g]  = bus.addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[g] = bus.wdata[g*WORD_SIZE +: WORD_SIZE];
    end

    // Requests are masked while reset is held so nothing reaches the RAM.
    assign w_req = bus.req & {NREQ{reset}};

    mcpu_rr_pick u_pick (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_win (w_win),
        .o_any (w_any)
    );

    assign bus.gnt       = w_gnt;
    assign bus.ram_en    = w_any;
    assign bus.ram_we    = w_any & bus.we[w_win];
    assign bus.ram_addr  = w_addr[w_win];
    assign bus.ram_wdata = w_wdata[w_win];
    assign bus.rvalid    = r_rd_tag;
    assign bus.rdata     = bus.ram_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr    <= '0;
            r_rd_tag <= '0;
        end else begin
            if (w_any) begin
                r_ptr <= next_ptr(w_win);
            end
            r_rd_tag <= (w_any && !bus.we[w_win]) ? w_gnt : '0;
        end
    end
endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Bench for mcpu_mem_arbiter: vector table plus a read-data scoreboard against a shadow memory.
module tb_mcpu_mem_arbiter;
    import mcpu_pkg::*;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [2:0]  we;
        logic [23:0] addr;
        logic [47:0] wdata;
        logic [2:0]  gnt;
        logic        en;
        logic        rwe;
        logic [2:0]  rv;
        logic        drop;
    } vec_t;

    typedef struct {
        logic [2:0]  oh;
        logic [15:0] data;
    } sb_t;

    logic clk;
    logic reset;
    mcpu_mem_arbiter_if bus ();

    mcpu_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] ram_mem [256];
    logic [15:0] shadow  [256];
    sb_t         sb [$];
    vec_t        tbl [18];
    int          total;
    int          bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipelined single-port RAM behind the arbiter.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
    end

    function automatic vec_t mkv(input logic rst, input logic [2:0] req, input logic [2:0] we,
                                 input logic [23:0] addr, input logic [47:0] wdata,
                                 input logic [2:0] gnt, input logic en, input logic rwe,
                                 input logic [2:0] rv, input logic drop);
        vec_t v;
        v.rst = rst; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.gnt = gnt; v.en = en; v.rwe = rwe; v.rv = rv; v.drop = drop;
        return v;
    endfunction

    function automatic int oh2idx(input logic [2:0] oh);
        for (int i = 0; i < 3; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm);
        sb_t e;
        if (bus.rvalid !== 3'b000) begin
            if (sb.size() == 0) begin
                chk({nm, ".sb_unexpected_rvalid"}, 16'(bus.rvalid), 16'h0);
            end else begin
                e = sb.pop_front();
                chk({nm, ".sb_rvalid"}, 16'(bus.rvalid), 16'(e.oh));
                chk({nm, ".sb_rdata"}, bus.rdata, e.data);
            end
        end
    endtask

    task automatic run(input vec_t v, input string nm);
        int          w;
        logic [7:0]  wa;
        logic [15:0] wd;
        reset     = v.rst;
        bus.req   = v.req;
        bus.we    = v.we;
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
        @(negedge clk);
        sb_check(nm);
        chk({nm, ".gnt"},    16'(bus.gnt),    16'(v.gnt));
        chk({nm, ".ram_en"}, 16'(bus.ram_en), 16'(v.en));
        chk({nm, ".ram_we"}, 16'(bus.ram_we), 16'(v.rwe));
        chk({nm, ".rvalid"}, 16'(bus.rvalid), 16'(v.rv));
        if (v.en) begin
            w  = oh2idx(v.gnt);
            wa = 8'(v.addr >> (8 * w));
            wd = 16'(v.wdata >> (16 * w));
            chk({nm, ".ram_addr"}, 16'(bus.ram_addr), 16'(wa));
            if (v.rwe) begin
                chk({nm, ".ram_wdata"}, bus.ram_wdata, wd);
                shadow[wa] = wd;
            end else if (!v.drop) begin
                sb.push_back('{oh: v.gnt, data: shadow[wa]});
            end
        end
        if (v.drop) begin
            #1 reset = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 16'hC000 + 16'(i);
            shadow[i]  = 16'hC000 + 16'(i);
        end
        ram_mem[8'h64] = 16'h0020;
        shadow[8'h64]  = 16'h0020;
        bus.ram_rdata  = '0;

        // reset with all requesting, then fairness 0,1,2,0,1,2
        tbl[0]  = mkv(0, 3'b111, 3'b000, 24'h020100, 48'h0, 3'b000, 0, 0, 3'b000, 0);
        tbl[1]  = mkv(0, 3'b111, 3'b000, 24'h020100, 48'h0, 3'b000, 0, 0, 3'b000, 0);
        tbl[2]  = mkv(1, 3'b111, 3'b000, 24'h020100, 48'h0, 3'b001, 1, 0, 3'b000, 0);
        tbl[3]  = mkv(1, 3'b111, 3'b000, 24'h020100, 48'h0, 3'b010, 1, 0, 3'b001, 0);
        tbl[4]  = mkv(1, 3'b111, 3'b000, 24'h020100, 48'h0, 3'b100, 1, 0, 3'b010, 0);
        tbl[5]  = mkv(1, 3'b111, 3'b000, 24'h020100, 48'h0, 3'b001, 1, 0, 3'b100, 0);
        tbl[6]  = mkv(1, 3'b111, 3'b000, 24'h020100, 48'h0, 3'b010, 1, 0, 3'b001, 0);
        tbl[7]  = mkv(1, 3'b111, 3'b000, 24'h020100, 48'h0, 3'b100, 1, 0, 3'b010, 0);
        // loader write then fetch read of the same word
        tbl[8]  = mkv(1, 3'b100, 3'b100, 24'h000100, {16'h1020, 32'h0}, 3'b100, 1, 1, 3'b100, 0);
        tbl[9]  = mkv(1, 3'b001, 3'b000, 24'h000100, 48'h0, 3'b001, 1, 0, 3'b000, 0);
        tbl[10] = mkv(1, 3'b000, 3'b000, 24'h000100, 48'h0, 3'b000, 0, 0, 3'b001, 0);
        // data read tagged while fetch waits
        tbl[11] = mkv(1, 3'b011, 3'b000, 24'h006410, 48'h0, 3'b010, 1, 0, 3'b000, 0);
        tbl[12] = mkv(1, 3'b001, 3'b000, 24'h006410, 48'h0, 3'b001, 1, 0, 3'b010, 0);
        tbl[13] = mkv(1, 3'b000, 3'b000, 24'h006410, 48'h0, 3'b000, 0, 0, 3'b001, 0);
        // simultaneous read (1) and write (2): one at a time, write lands
        tbl[14] = mkv(1, 3'b110, 3'b100, 24'h646400, {16'hBEEF, 32'h0}, 3'b010, 1, 0, 3'b000, 0);
        tbl[15] = mkv(1, 3'b100, 3'b100, 24'h646400, {16'hBEEF, 32'h0}, 3'b100, 1, 1, 3'b010, 0);
        tbl[16] = mkv(1, 3'b010, 3'b000, 24'h646400, 48'h0, 3'b010, 1, 0, 3'b000, 0);
        tbl[17] = mkv(1, 3'b000, 3'b000, 24'h646400, 48'h0, 3'b000, 0, 0, 3'b010, 0);

        for (int i = 0; i < 18; i++) begin
            run(tbl[i], $sformatf("vec%0d", i));
        end

        // idle pointer hold: grant to 1, three idle cycles, then all request
        run(mkv(1, 3'b010, 3'b000, 24'h026400, 48'h0, 3'b010, 1, 0, 3'b000, 0), "hold_g1");
        run(mkv(1, 3'b000, 3'b000, 24'h026400, 48'h0, 3'b000, 0, 0, 3'b010, 0), "hold_idle0");
        run(mkv(1, 3'b000, 3'b000, 24'h026400, 48'h0, 3'b000, 0, 0, 3'b000, 0), "hold_idle1");
        run(mkv(1, 3'b000, 3'b000, 24'h026400, 48'h0, 3'b000, 0, 0, 3'b000, 0), "hold_idle2");
        run(mkv(1, 3'b111, 3'b000, 24'h026400, 48'h0, 3'b100, 1, 0, 3'b000, 0), "hold_all");
        run(mkv(1, 3'b000, 3'b000, 24'h026400, 48'h0, 3'b000, 0, 0, 3'b100, 0), "hold_rv");

        // reset sampled in the cycle a read is granted: no rvalid afterwards
        run(mkv(1, 3'b001, 3'b000, 24'h000005, 48'h0, 3'b001, 1, 0, 3'b000, 1), "mid_gnt");
        run(mkv(0, 3'b001, 3'b000, 24'h000005, 48'h0, 3'b000, 0, 0, 3'b000, 0), "mid_rst");
        run(mkv(1, 3'b000, 3'b000, 24'h000005, 48'h0, 3'b000, 0, 0, 3'b000, 0), "mid_idle0");
        run(mkv(1, 3'b000, 3'b000, 24'h000005, 48'h0, 3'b000, 0, 0, 3'b000, 0), "mid_idle1");
        run(mkv(1, 3'b101, 3'b000, 24'h070005, 48'h0, 3'b001, 1, 0, 3'b000, 0), "post_gnt0");
        run(mkv(1, 3'b100, 3'b000, 24'h070005, 48'h0, 3'b100, 1, 0, 3'b001, 0), "post_gnt2");
        run(mkv(1, 3'b000, 3'b000, 24'h070005, 48'h0, 3'b000, 0, 0, 3'b100, 0), "post_rv2");

        chk("sb_drained", 16'(sb.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
